// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between an upstream client and alu_cmd_sequencer.
// The client holds the master modport; the sequencer holds the slave modport.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Front-end for the multi-cycle ALU: takes one command per handshake, drives the ALU pin
// protocol (reset, start, A, B), captures the result and returns it with a timeout watchdog.
module alu_cmd_sequencer #(
  parameter int ALU_RST_CYCLES = 1,
  parameter int TIMEOUT        = 64,
  parameter int TO_W           = 7
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output logic                busy,
  output logic                alu_rst,
  output logic                alu_start,
  output logic [1:0]          alu_sel,
  output logic [15:0]         alu_inbus,
  input  logic [15:0]         alu_outbus,
  input  logic                alu_finish
);

  localparam int RC_W = $clog2(ALU_RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    START,
    HOLD,
    OPB,
    CAPT,
    DONE
  } state_t;

  state_t state, next_state;

  logic [RC_W-1:0] rst_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      op_q;
  logic [15:0]     a_q;
  logic [7:0]      b_q;

  logic            alu_rst_d, alu_start_d;
  logic [1:0]      alu_sel_d;
  logic [15:0]     alu_inbus_d;
  logic            rsp_valid_d, rsp_valid_q;
  logic [15:0]     rsp_data_d, rsp_data_q;
  logic            rsp_err_d, rsp_err_q;

  logic            accept, rst_last, timed_out;

  assign bus.cmd_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = bus.cmd_valid && (state == IDLE);
  assign rst_last      = (rst_cnt == RC_W'(ALU_RST_CYCLES - 1));
  // to_cnt equals the number of cycles since START began, so TIMEOUT-1 is the last OPB cycle.
  assign timed_out     = (to_cnt == TO_W'(TIMEOUT - 1));

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.cmd_valid) next_state = CLR;
      CLR:   if (rst_last) next_state = START;
      START: next_state = HOLD;
      HOLD:  next_state = OPB;
      OPB: begin
        if (alu_finish)     next_state = CAPT;
        else if (timed_out) next_state = DONE;
      end
      CAPT:  next_state = DONE;
      DONE:  if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every ALU-side and response output is the registered image of the state being entered.
  always_comb begin
    alu_rst_d   = (next_state == CLR);
    alu_start_d = (next_state == START);
    alu_sel_d   = 2'b00;
    alu_inbus_d = 16'h0000;
    rsp_valid_d = (next_state == DONE);
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (next_state)
      START, HOLD: begin
        alu_sel_d   = op_q;
        alu_inbus_d = a_q;
      end
      OPB, CAPT: begin
        alu_sel_d   = op_q;
        alu_inbus_d = {8'h00, b_q};
      end
      default: ;
    endcase
    if (state == CAPT) begin
      rsp_data_d = alu_outbus;
      rsp_err_d  = 1'b0;
    end else if ((state == OPB) && (next_state == DONE)) begin
      rsp_data_d = 16'h0000;
      rsp_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_rst     <= 1'b1;
      alu_start   <= 1'b0;
      alu_sel     <= 2'b00;
      alu_inbus   <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      alu_rst     <= alu_rst_d;
      alu_start   <= alu_start_d;
      alu_sel     <= alu_sel_d;
      alu_inbus   <= alu_inbus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Only division uses the upper operand byte, so it is cleared for the other ops at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 2'b00;
      a_q  <= 16'h0000;
      b_q  <= 8'h00;
    end else if (accept) begin
      op_q <= bus.cmd_op;
      a_q  <= (bus.cmd_op == 2'b11) ? bus.cmd_a : {8'h00, bus.cmd_a[7:0]};
      b_q  <= bus.cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (accept)             rst_cnt <= '0;
      else if (state == CLR)  rst_cnt <= rst_cnt + 1'b1;

      if (state == CLR) begin
        to_cnt <= '0;
      end else if (((state == START) || (state == HOLD) || (state == OPB)) &&
                   (to_cnt != TO_W'(TIMEOUT))) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural multi-cycle ALU stub whose
// finish latency can be tuned or suppressed.
module tb_alu_cmd_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        alu_rst;
  logic        alu_start;
  logic [1:0]  alu_sel;
  logic [15:0] alu_inbus;
  logic [15:0] alu_outbus = 16'h0000;
  logic        alu_finish = 1'b0;

  int checks = 0;
  int passes = 0;

  logic        stub_hang = 1'b0;
  int          stub_lat  = 3;
  int          stub_phase = 0;
  int          stub_cnt  = 0;
  logic [1:0]  stub_sel  = 2'b00;
  logic [15:0] stub_a    = 16'h0000;
  logic [7:0]  stub_b    = 8'h00;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(
    .ALU_RST_CYCLES (1),
    .TIMEOUT        (TIMEOUT),
    .TO_W           (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .alu_rst    (alu_rst),
    .alu_start  (alu_start),
    .alu_sel    (alu_sel),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_finish (alu_finish)
  );

  function automatic logic [15:0] alu_model(input logic [1:0] sel, input logic [15:0] a,
                                            input logic [7:0] b);
    logic [15:0] bw;
    bw = {8'h00, b};
    case (sel)
      2'b00:   return {8'h00, a[7:0]} + bw;
      2'b01:   return {8'h00, a[7:0]} - bw;
      2'b10:   return {8'h00, a[7:0]} * bw;
      default: return (b == 8'h00) ? 16'hFFFF : {8'(a % bw), 8'(a / bw)};
    endcase
  endfunction

  // ALU stub: A is taken while start is high, B two cycles later, finish after stub_lat more.
  always @(posedge clk) begin
    if (alu_rst) begin
      stub_phase <= 0;
      stub_cnt   <= 0;
      alu_finish <= 1'b0;
      alu_outbus <= 16'h0000;
    end else begin
      case (stub_phase)
        0: if (alu_start) begin
             stub_a     <= alu_inbus;
             stub_sel   <= alu_sel;
             stub_phase <= 1;
           end
        1: stub_phase <= 2;
        2: begin
             stub_b     <= alu_inbus[7:0];
             stub_cnt   <= 0;
             stub_phase <= 3;
           end
        3: if (!stub_hang) begin
             if (stub_cnt == stub_lat) begin
               alu_finish <= 1'b1;
               alu_outbus <= alu_model(stub_sel, stub_a, stub_b);
               stub_phase <= 4;
             end else begin
               stub_cnt <= stub_cnt + 1;
             end
           end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Presents a command and returns at the falling edge inside the CLR cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cnt;
    int          starts;
    logic        stable_ok;
    logic        ready_seen;
    logic        rsp_seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = 16'h0000;
    bus.cmd_b     = 8'h00;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("reset_alu_rst",   32'(alu_rst),       32'd1);
    checkOutput("reset_alu_start", 32'(alu_start),     32'd0);
    checkOutput("reset_alu_sel",   32'(alu_sel),       32'd0);
    checkOutput("reset_alu_inbus", 32'(alu_inbus),     32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_data",  32'(bus.rsp_data),  32'd0);
    checkOutput("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_alu_rst",   32'(alu_rst),       32'd0);
    checkOutput("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("post_reset_busy",      32'(busy),          32'd0);

    // add 40 + 12 with a cycle-by-cycle look at the ALU pins
    applyStimulus(2'b00, 16'd40, 8'd12);
    checkOutput("add_clr_alu_rst",  32'(alu_rst),       32'd1);
    checkOutput("add_clr_busy",     32'(busy),          32'd1);
    checkOutput("add_clr_cmd_rdy",  32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("add_start_pulse",  32'(alu_start),     32'd1);
    checkOutput("add_start_alu_rst",32'(alu_rst),       32'd0);
    checkOutput("add_start_inbus",  32'(alu_inbus),     32'd40);
    @(negedge clk);
    checkOutput("add_hold_start",   32'(alu_start),     32'd0);
    checkOutput("add_hold_inbus",   32'(alu_inbus),     32'd40);
    @(negedge clk);
    checkOutput("add_opb_inbus",    32'(alu_inbus),     32'd12);
    waitRsp("add_rsp_wait");
    checkOutput("add_rsp_data",     32'(bus.rsp_data),  32'h0034);
    checkOutput("add_rsp_err",      32'(bus.rsp_err),   32'd0);
    checkOutput("add_done_inbus",   32'(alu_inbus),     32'd0);
    @(negedge clk);
    checkOutput("add_rsp_once",     32'(bus.rsp_valid), 32'd0);
    checkOutput("add_idle_ready",   32'(bus.cmd_ready), 32'd1);
    checkOutput("add_idle_sel",     32'(alu_sel),       32'd0);

    // sub with junk in A[15:8], which must not reach the ALU
    applyStimulus(2'b01, 16'h7728, 8'd12);
    @(negedge clk);
    checkOutput("sub_start_inbus",  32'(alu_inbus),     32'h0028);
    checkOutput("sub_start_sel",    32'(alu_sel),       32'd1);
    waitRsp("sub_rsp_wait");
    checkOutput("sub_rsp_data",     32'(bus.rsp_data),  32'h001C);

    applyStimulus(2'b10, 16'd40, 8'd12);
    waitRsp("mul_rsp_wait");
    checkOutput("mul_rsp_data",     32'(bus.rsp_data),  32'h01E0);
    checkOutput("mul_rsp_err",      32'(bus.rsp_err),   32'd0);

    // div 11542 / 135 -> rem 67, quot 85
    applyStimulus(2'b11, 16'd11542, 8'd135);
    @(negedge clk);
    checkOutput("div_start_inbus",  32'(alu_inbus),     32'h2D16);
    checkOutput("div_start_sel",    32'(alu_sel),       32'd3);
    @(negedge clk);
    checkOutput("div_hold_inbus_hi",32'(alu_inbus[15:8]), 32'h2D);
    waitRsp("div_rsp_wait");
    checkOutput("div_rsp_data",     32'(bus.rsp_data),  32'h4355);

    // backpressure: response held, a second command waits with cmd_valid high
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    applyStimulus(2'b00, 16'd40, 8'd12);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_a     = 16'd40;
    bus.cmd_b     = 8'd12;
    waitRsp("bp_rsp_wait");
    starts     = 0;
    stable_ok  = 1'b1;
    ready_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (alu_start) starts++;
      if (bus.cmd_ready) ready_seen = 1'b1;
      if (!bus.rsp_valid || bus.rsp_data !== 16'h0034 || bus.rsp_err !== 1'b0) stable_ok = 1'b0;
    end
    checkOutput("bp_rsp_stable",    32'(stable_ok),     32'd1);
    checkOutput("bp_no_ready",      32'(ready_seen),    32'd0);
    checkOutput("bp_no_start",      32'(starts),        32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_idle_valid",    32'(bus.rsp_valid), 32'd0);
    checkOutput("bp_idle_ready",    32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("bp_next_accept",   32'(busy),          32'd1);
    checkOutput("bp_next_clr",      32'(alu_rst),       32'd1);
    waitRsp("bp_next_rsp_wait");
    checkOutput("bp_next_rsp_data", 32'(bus.rsp_data),  32'h001C);

    // timeout: the ALU never finishes
    @(negedge clk);
    stub_hang = 1'b1;
    applyStimulus(2'b00, 16'd40, 8'd12);
    cnt = 0;
    while (!alu_start && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("to_start_seen",    32'(alu_start),     32'd1);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("to_latency",       32'(cnt),           32'(TIMEOUT));
    checkOutput("to_rsp_err",       32'(bus.rsp_err),   32'd1);
    checkOutput("to_rsp_data",      32'(bus.rsp_data),  32'd0);
    stub_hang = 1'b0;
    @(negedge clk);
    applyStimulus(2'b00, 16'd40, 8'd12);
    waitRsp("to_after_rsp_wait");
    checkOutput("to_after_data",    32'(bus.rsp_data),  32'h0034);
    checkOutput("to_after_err",     32'(bus.rsp_err),   32'd0);

    // finish seen on the last cycle before timeout is still honoured
    @(negedge clk);
    stub_lat = 59;
    applyStimulus(2'b10, 16'd40, 8'd12);
    waitRsp("edge_in_rsp_wait");
    checkOutput("edge_in_err",      32'(bus.rsp_err),   32'd0);
    checkOutput("edge_in_data",     32'(bus.rsp_data),  32'h01E0);

    // one cycle later is too late
    @(negedge clk);
    stub_lat = 60;
    applyStimulus(2'b10, 16'd40, 8'd12);
    waitRsp("edge_out_rsp_wait");
    checkOutput("edge_out_err",     32'(bus.rsp_err),   32'd1);
    checkOutput("edge_out_data",    32'(bus.rsp_data),  32'd0);

    // reset while a mul is waiting in OPB
    @(negedge clk);
    stub_lat = 20;
    applyStimulus(2'b10, 16'd40, 8'd12);
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_in_opb",   32'(alu_inbus),     32'd12);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_alu_rst",  32'(alu_rst),       32'd1);
    checkOutput("rst_mid_rsp_valid",32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_mid_busy",     32'(busy),          32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stub_lat = 3;
    @(negedge clk);
    checkOutput("rst_rel_ready",    32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_rel_alu_rst",  32'(alu_rst),       32'd0);
    rsp_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen = 1'b1;
    end
    checkOutput("rst_no_rsp",       32'(rsp_seen),      32'd0);
    applyStimulus(2'b00, 16'd40, 8'd12);
    waitRsp("rst_fresh_rsp_wait");
    checkOutput("rst_fresh_data",   32'(bus.rsp_data),  32'h0034);
    checkOutput("rst_fresh_err",    32'(bus.rsp_err),   32'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
